hash_round_scheduler: RTL and testbench

Sequencing and arbitration controller for the 128-bit keyed hash datapath. It shares one iterative round engine between `NUM_REQ` requesters using round-robin arbitration. It holds the secret key and refuses work until a key is loaded. Each job runs a fixed number of keyed mixing rounds instead of a single constant XOR. It sits between the requesting blocks and the hash result consumer.

---
 rtl/hash_round_scheduler_pkg.sv | 28 ++
 rtl/hash_round_scheduler_if.sv | 28 ++
 rtl/hash_round_scheduler_core.sv | 13 +
 rtl/hash_round_scheduler.sv | 125 ++++++++++++
 tb/tb_hash_round_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_round_scheduler_pkg.sv
// hash_sched_pkg: shared constants, FSM states and helpers
// for the keyed hash round scheduler (RC, rotl1, id width).
package hash_sched_pkg;

  localparam int DW = 128;

  localparam logic [DW-1:0] RC = {
    32'h5A5A5A5A, 32'hA5A5A5A5,
    32'h5A5A5A5A, 32'hA5A5A5A5
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  function automatic logic [DW-1:0] rotl1(
    input logic [DW-1:0] t
  );
    return {t[DW-2:0], t[DW-1]};
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_round_scheduler_if.sv
// Requester/consumer bundle of the hash round scheduler.
// req_valid/req_ready/req_data in, rsp_valid/rsp_ready/rsp_data/rsp_id out.
interface hash_round_scheduler_if #(
  parameter int NUM_REQ = 2
);
  import hash_sched_pkg::*;

  localparam int IDW = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/hash_round_scheduler_core.sv
// hash_round_core: one combinational keyed mixing round.
// Ports: s, key in; s_next = rotl1(s ^ key) ^ RC out.
module hash_round_core
  import hash_sched_pkg::*;
(
  input  logic [DW-1:0] s,
  input  logic [DW-1:0] key,
  output logic [DW-1:0] s_next
);

  assign s_next = rotl1(s ^ key) ^ RC;

endmodule

// File: rtl/hash_round_scheduler.sv
// hash_round_scheduler: round-robin job arbiter around one iterated
// keyed round engine. Ports: clk, rst_n, key_we/key_in/key_err, busy,
// bus (slave: requests in, response out). Optional HASH_SCHED_KEY_LOCK_EN
// makes the key write-once per reset.
module hash_round_scheduler
  import hash_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ROUNDS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_we,
  input  logic [DW-1:0] key_in,
  output logic          key_err,
  output logic          busy,
  hash_round_scheduler_if.slave bus
);

  localparam int IDW = id_w(NUM_REQ);
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [IDW-1:0] LAST_REQ = IDW'(NUM_REQ - 1);

  state_e         state_q, state_d;
  logic [DW-1:0]  s_q, key_r, s_nxt;
  logic [IDW-1:0] id_q, last_q, win;
  logic [3:0]     cnt_q;
  logic           key_loaded, key_locked;
  logic           win_ok, key_acc, grant_en, accept;
  int             idx;

  assign key_acc  = key_we && (state_q == IDLE) && !key_locked;
  assign grant_en = (state_q == IDLE) && key_loaded && !key_acc;
  assign accept   = grant_en && win_ok;

`ifdef HASH_SCHED_KEY_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_locked <= 1'b0;
    end else if (key_acc) begin
      key_locked <= 1'b1;
    end
  end
`else
  assign key_locked = 1'b0;
`endif

  // Descending scan so the requester nearest after last wins.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        win    = IDW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[win] = 1'b1;
    end
  end

  hash_round_core u_core (
    .s      (s_q),
    .key    (key_r),
    .s_next (s_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (cnt_q == LAST_RND) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = s_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      id_q       <= '0;
      last_q     <= LAST_REQ;
      cnt_q      <= '0;
      key_r      <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      key_err <= key_we && !key_acc;
      if (key_acc) begin
        key_r      <= key_in;
        key_loaded <= 1'b1;
      end
      if (accept) begin
        s_q    <= bus.req_data[int'(win)*DW +: DW];
        id_q   <= win;
        last_q <= win;
        cnt_q  <= '0;
      end else if (state_q == ROUND) begin
        s_q   <= s_nxt;
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hash_round_scheduler.sv
// Directed bench for hash_round_scheduler: ROUNDS=1/2 instances for
// hand-computed results, ROUNDS=4 instance for arbitration and keys.
module tb_hash_round_scheduler;

  localparam logic [127:0] RC_TB = {
    32'h5A5A5A5A, 32'hA5A5A5A5,
    32'h5A5A5A5A, 32'hA5A5A5A5
  };
  localparam logic [127:0] K1 = {4{32'h01234567}};
  localparam logic [127:0] K2 = {4{32'hF0E1D2C3}};
  localparam logic [127:0] DA = {4{32'hCAFEBABE}};
  localparam logic [127:0] DB = {4{32'h13579BDF}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  hash_round_scheduler_if #(.NUM_REQ(2)) b1();
  hash_round_scheduler_if #(.NUM_REQ(2)) b2();
  hash_round_scheduler_if #(.NUM_REQ(2)) b4();

  logic         kwe1, kwe2, kwe4;
  logic [127:0] kin1, kin2, kin4;
  logic         kerr1, kerr2, kerr4;
  logic         busy1, busy2, busy4;

  hash_round_scheduler #(.NUM_REQ(2), .ROUNDS(1)) d1 (
    .clk(clk), .rst_n(rst_n), .key_we(kwe1), .key_in(kin1),
    .key_err(kerr1), .busy(busy1), .bus(b1.slave)
  );
  hash_round_scheduler #(.NUM_REQ(2), .ROUNDS(2)) d2 (
    .clk(clk), .rst_n(rst_n), .key_we(kwe2), .key_in(kin2),
    .key_err(kerr2), .busy(busy2), .bus(b2.slave)
  );
  hash_round_scheduler #(.NUM_REQ(2), .ROUNDS(4)) d4 (
    .clk(clk), .rst_n(rst_n), .key_we(kwe4), .key_in(kin4),
    .key_err(kerr4), .busy(busy4), .bus(b4.slave)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  vec_t tv[4];

  function automatic logic [127:0] model(
    input logic [127:0] k, input logic [127:0] d, input int r
  );
    logic [127:0] s, t;
    s = d;
    for (int i = 0; i < r; i++) begin
      t = s ^ k;
      s = {t[126:0], t[127]} ^ RC_TB;
    end
    return s;
  endfunction

  task automatic chk(
    input string nm, input logic [127:0] act, input logic [127:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kwe1 = 0; kwe2 = 0; kwe4 = 0;
    kin1 = '0; kin2 = '0; kin4 = '0;
    b1.req_valid = '0; b1.req_data = '0; b1.rsp_ready = 0;
    b2.req_valid = '0; b2.req_data = '0; b2.rsp_ready = 0;
    b4.req_valid = '0; b4.req_data = '0; b4.rsp_ready = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_key4(input logic [127:0] k);
    kwe4 = 1'b1;
    kin4 = k;
    step();
    kwe4 = 1'b0;
  endtask

  task automatic wait_rsp4(output int lat);
    lat = 0;
    while (!b4.rsp_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  // Wait for grant to ei, run the job and take the response.
  task automatic serve4(
    input int ei, input logic [127:0] ed, input bit drop,
    input string nm
  );
    int n;
    int lat;
    n = 0;
    #1;
    while (b4.req_ready == 2'b00 && n < 30) begin
      step();
      #1;
      n++;
    end
    chk({nm, " grant"}, 128'(b4.req_ready), 128'(2'b01 << ei));
    step();
    if (drop) b4.req_valid[ei] = 1'b0;
    wait_rsp4(lat);
    chk({nm, " latency"}, 128'(lat), 128'(4));
    chk({nm, " data"}, b4.rsp_data, ed);
    chk({nm, " id"}, 128'(b4.rsp_id), 128'(ei));
    b4.rsp_ready = 1'b1;
    step();
    b4.rsp_ready = 1'b0;
    chk({nm, " busy after"}, 128'(busy4), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int lat;
    logic [127:0] ek;
    logic [1:0] ready_lock;

    tv[0] = '{128'h0, 128'h0, 0, 128'h0};
    tv[1] = '{K1, DA, 1, 128'h0};
    tv[2] = '{K2, DB, 0, 128'h0};
    tv[3] = '{{2{64'h0F0F0F0F_00000001}}, {128{1'b1}}, 1, 128'h0};
    for (int i = 0; i < 4; i++)
      tv[i].exp = model(tv[i].key, tv[i].data, 4);

    do_reset();

    // reset values
    chk("rst rsp_valid", 128'(b4.rsp_valid), 128'(0));
    chk("rst busy", 128'(busy4), 128'(0));
    chk("rst key_err", 128'(kerr4), 128'(0));
    chk("rst rsp_data", b4.rsp_data, 128'h0);
    chk("rst rsp_id", 128'(b4.rsp_id), 128'(0));

    // no key loaded: never a grant
    b4.req_valid = 2'b11;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b4.req_ready != 2'b00) ok = 1'b0;
      step();
    end
    chk("nokey ready", 128'(ok), 128'(1));
    b4.req_valid = 2'b00;

    // single and two-round hand-computed results
    do_reset();
    kwe1 = 1; kwe2 = 1;
    step();
    kwe1 = 0; kwe2 = 0;
    b1.req_valid = 2'b01;
    b2.req_valid = 2'b01;
    #1;
    chk("r1 grant", 128'(b1.req_ready), 128'(2'b01));
    chk("r2 grant", 128'(b2.req_ready), 128'(2'b01));
    step();
    b1.req_valid = 2'b00;
    b2.req_valid = 2'b00;
    chk("r1 valid early", 128'(b1.rsp_valid), 128'(0));
    chk("r1 busy", 128'(busy1), 128'(1));
    step();
    chk("r1 valid", 128'(b1.rsp_valid), 128'(1));
    chk("r1 data", b1.rsp_data, RC_TB);
    chk("r1 id", 128'(b1.rsp_id), 128'(0));
    chk("r2 valid early", 128'(b2.rsp_valid), 128'(0));
    step();
    chk("r2 valid", 128'(b2.rsp_valid), 128'(1));
    chk("r2 data", b2.rsp_data, {4{32'hEEEEEEEF}});
    chk("r1 hold", b1.rsp_data, RC_TB);
    chk("r kerr", 128'({kerr1, kerr2}), 128'(0));
    b1.rsp_ready = 1; b2.rsp_ready = 1;
    step();
    b1.rsp_ready = 0; b2.rsp_ready = 0;
    chk("r busy off", 128'({busy1, busy2}), 128'(0));

    // table-driven jobs on the 4-round instance
    for (int i = 0; i < 4; i++) begin
      do_reset();
      load_key4(tv[i].key);
      b4.req_data[tv[i].idx*128 +: 128] = tv[i].data;
      b4.req_valid[tv[i].idx] = 1'b1;
      serve4(tv[i].idx, tv[i].exp, 1'b1, $sformatf("vec%0d", i));
    end

    // round-robin with both requesters always valid
    do_reset();
    load_key4(K1);
    b4.req_data = {DB, DA};
    b4.req_valid = 2'b11;
    serve4(0, model(K1, DA, 4), 1'b0, "rr0");
    serve4(1, model(K1, DB, 4), 1'b0, "rr1");
    serve4(0, model(K1, DA, 4), 1'b0, "rr2");
    b4.req_valid = 2'b10;
    serve4(1, model(K1, DB, 4), 1'b1, "rr3");

    // key write while busy, then in IDLE
    do_reset();
    load_key4(K1);
    b4.req_data = {DB, DA};
    b4.req_valid = 2'b01;
    #1;
    chk("kb grant", 128'(b4.req_ready), 128'(2'b01));
    step();
    b4.req_valid = 2'b00;
    kwe4 = 1; kin4 = K2;
    step();
    kwe4 = 0;
    chk("kb key_err", 128'(kerr4), 128'(1));
    step();
    chk("kb key_err end", 128'(kerr4), 128'(0));
    wait_rsp4(lat);
    chk("kb data", b4.rsp_data, model(K1, DA, 4));
    b4.rsp_ready = 1;
    step();
    b4.rsp_ready = 0;
    b4.req_valid = 2'b11;
    kwe4 = 1; kin4 = K2;
    #1;
`ifdef HASH_SCHED_KEY_LOCK_EN
    ready_lock = 2'b10;
    ek = K1;
`else
    ready_lock = 2'b00;
    ek = K2;
`endif
    chk("ki ready", 128'(b4.req_ready), 128'(ready_lock));
    b4.req_valid = 2'b00;
    step();
    kwe4 = 0;
`ifdef HASH_SCHED_KEY_LOCK_EN
    chk("ki key_err", 128'(kerr4), 128'(1));
`else
    chk("ki key_err", 128'(kerr4), 128'(0));
`endif
    b4.req_valid = 2'b10;
    serve4(1, model(ek, DB, 4), 1'b1, "ki job");

    // reset in the middle of a job
    do_reset();
    load_key4(K1);
    b4.req_data = {DB, DA};
    b4.req_valid = 2'b01;
    step();
    b4.req_valid = 2'b00;
    step();
    rst_n = 1'b0;
    #1;
    chk("mr rsp_valid", 128'(b4.rsp_valid), 128'(0));
    chk("mr busy", 128'(busy4), 128'(0));
    step();
    rst_n = 1'b1;
    b4.req_valid = 2'b11;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (b4.req_ready != 2'b00 || b4.rsp_valid) ok = 1'b0;
      step();
    end
    chk("mr no grant", 128'(ok), 128'(1));
    b4.req_valid = 2'b00;
    load_key4(K2);
    b4.req_valid = 2'b01;
    serve4(0, model(K2, DA, 4), 1'b1, "mr reload");

    // back-pressure in DONE
    b4.req_valid = 2'b11;
    serve4(1, model(K2, DB, 4), 1'b0, "bp first");
    wait_rsp4(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp data", b4.rsp_data, model(K2, DA, 4));
      chk("bp id", 128'(b4.rsp_id), 128'(0));
      chk("bp ready", 128'(b4.req_ready), 128'(0));
      step();
    end
    chk("bp valid", 128'(b4.rsp_valid), 128'(1));
    b4.rsp_ready = 1;
    step();
    b4.rsp_ready = 0;
    b4.req_valid = 2'b00;
    chk("bp done busy", 128'(busy4), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
